// File: rtl/main_fsm.sv
// main_fsm: multicycle RISC-V control FSM; Moore outputs per state,
// with op consulted only for next-state and the Decode-time illegal_op flag.
module main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    output logic       Branch,
    output logic       PCUpdate,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       illegal_op,
    output logic [3:0] state
);
    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                           S_MEMREAD = 4'd3, S_MEMWB = 4'd4, S_MEMWRITE = 4'd5,
                           S_EXECR = 4'd6, S_ALUWB = 4'd7, S_EXECI = 4'd8,
                           S_JAL = 4'd9, S_BEQ = 4'd10;
    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BEQ = 7'b1100011;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_legal;

    assign state   = r_state;
    assign w_legal = op == OP_LW || op == OP_SW || op == OP_R || op == OP_I ||
                     op == OP_JAL || op == OP_BEQ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = S_DECODE;
            S_DECODE:  w_next = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                                op == OP_R   ? S_EXECR :
                                op == OP_I   ? S_EXECI :
                                op == OP_JAL ? S_JAL   :
                                op == OP_BEQ ? S_BEQ   : S_FETCH;
            S_MEMADR:  w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: w_next = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL: w_next = S_ALUWB;
            default:   w_next = S_FETCH;
        endcase
    end

    // Unused states 11..15 fall through to the all-zero defaults.
    always_comb begin
        Branch     = 1'b0;
        PCUpdate   = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        illegal_op = r_state == S_DECODE && !w_legal;
        case (r_state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCUpdate  = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                PCUpdate = 1'b1;
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                Branch  = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: random instruction streams with occasional async resets,
// checked against a per-instruction state-path and per-state output table.
module tb_main_fsm;
    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       Branch, PCUpdate, RegWrite, MemWrite, IRWrite, AdrSrc, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [3:0] dut_state;
    int         n_vec = 0;
    int         n_err = 0;

    typedef int q_t[$];

    main_fsm dut (
        .clk(clk), .reset(reset), .op(op),
        .Branch(Branch), .PCUpdate(PCUpdate), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .illegal_op(illegal_op), .state(dut_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Packed as {Branch,PCUpdate,RegWrite,MemWrite,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}
    function automatic logic [13:0] pack(input logic br, pc, rw, mw, ir, adr,
                                         input logic [1:0] rs, sa, sb, ao);
        return {br, pc, rw, mw, ir, adr, rs, sa, sb, ao};
    endfunction

    function automatic logic [13:0] exp_out(input int s);
        case (s)
            0:  return pack(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00);
            1:  return pack(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00);
            2:  return pack(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00);
            3:  return pack(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
            4:  return pack(0, 0, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00);
            5:  return pack(0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
            6:  return pack(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10);
            7:  return pack(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
            8:  return pack(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10);
            9:  return pack(0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00);
            10: return pack(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01);
            default: return 14'd0;
        endcase
    endfunction

    function automatic q_t path_of(input logic [6:0] o);
        q_t q = {0, 1};
        case (o)
            7'b0000011: q = {q, 2, 3, 4};
            7'b0100011: q = {q, 2, 5};
            7'b0110011: q = {q, 6, 7};
            7'b0010011: q = {q, 8, 7};
            7'b1101111: q = {q, 9, 7};
            7'b1100011: q = {q, 10};
            default: ;
        endcase
        return q;
    endfunction

    function automatic logic [13:0] got_out();
        return pack(Branch, PCUpdate, RegWrite, MemWrite, IRWrite, AdrSrc,
                    ResultSrc, ALUSrcA, ALUSrcB, ALUOp);
    endfunction

    task automatic check_state(input string tag, input int s, input logic ill);
        check({tag, "_state"}, dut_state, s);
        check({tag, "_outs"}, got_out(), exp_out(s));
        check({tag, "_illegal"}, illegal_op, ill);
        check({tag, "_wr_excl"}, (32'(RegWrite) + MemWrite + IRWrite) <= 1, 1);
    endtask

    task automatic run_instr(input logic [6:0] o, input int rst_at);
        q_t q = path_of(o);
        for (int i = 0; i < q.size(); i++) begin
            if (i > 0) @(negedge clk);
            if (i == 0) op = o;
            else if (i >= 3) op = 7'($urandom);
            check_state($sformatf("op%02h_s%0d", o, i), q[i], q[i] == 1 && q.size() == 2);
            if (i == rst_at) begin
                #2 reset = 1'b1;
                #1 check_state("async_rst", 0, 1'b0);
                @(negedge clk);
                check_state("rst_held", 0, 1'b0);
                reset = 1'b0;
                return;
            end
        end
        @(negedge clk);
    endtask

    localparam logic [6:0] DIR_OPS[8] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h6F, 7'h63, 7'h7F, 7'h03};
    localparam logic [6:0] LEGAL[6]   = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h6F, 7'h63};

    initial begin
        reset = 1'b1;
        op    = 7'h7F;
        #3 check_state("reset", 0, 1'b0);
        @(negedge clk);
        check_state("reset_edge", 0, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) run_instr(DIR_OPS[k], k == 7 ? 3 : -1);
        for (int k = 0; k < 80; k++) begin
            logic [6:0] o;
            int ra;
            o  = $urandom_range(0, 9) < 6 ? LEGAL[$urandom_range(0, 5)] : 7'($urandom);
            ra = -1;
            if (path_of(o).size() >= 3 && $urandom_range(0, 4) == 0)
                ra = $urandom_range(2, path_of(o).size() - 1);
            run_instr(o, ra);
        end
        check_state("final", 0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
- No parameters.
- REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
- REQ-003 The block SHALL have port op, input, 7 bits: opcode field from the instruction register, stable from Decode onward.
- REQ-004 The block SHALL have port Branch, output, 1 bit: beq compare cycle.
- REQ-005 The block SHALL have port PCUpdate, output, 1 bit: unconditional PC write.
- REQ-006 The block SHALL have port RegWrite, output, 1 bit: register file write enable.
- REQ-007 The block SHALL have port MemWrite, output, 1 bit: data memory write enable.
- REQ-008 The block SHALL have port IRWrite, output, 1 bit: instruction register load.
- REQ-009 The block SHALL have port AdrSrc, output, 1 bit: memory address select; 0 = PC, 1 = ALU result.
- REQ-010 The block SHALL have ports ResultSrc, ALUSrcA, ALUSrcB and ALUOp, each output, 2 bits: result, ALU operand and ALU-operation selects.
- REQ-011 The block SHALL have port illegal_op, output, 1 bit: unsupported opcode flagged in Decode.
- REQ-012 The block SHALL have port state, output, 4 bits: current state encoding, for debug.

Function
- REQ-013 The block SHALL be a Moore FSM: all outputs a function of current state only, except next-state and illegal_op, which also depend on op.
- REQ-014 State encodings SHALL be 0 Fetch, 1 Decode, 2 MemAdr, 3 MemRead, 4 MemWB, 5 MemWrite, 6 ExecuteR, 7 ALUWB, 8 ExecuteI, 9 JAL, 10 BEQ.
- REQ-015 Any state value 11..15 SHALL go to Fetch on the next edge, with all outputs 0 while in it.
- REQ-016 Any select output not listed for a state SHALL be driven 2'b00 or 0; no X is ever driven.
- REQ-017 Fetch SHALL drive IRWrite=1, PCUpdate=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, and go next to Decode.
- REQ-018 Decode SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target).
- REQ-019 Decode SHALL go next to MemAdr for op 0000011 (lw) or 0100011 (sw).
- REQ-020 Decode SHALL go next to ExecuteR for op 0110011, ExecuteI for 0010011, JAL for 1101111, BEQ for 1100011.
- REQ-021 Decode SHALL go next to Fetch for any other op, with illegal_op=1 for that one cycle only.
- REQ-022 MemAdr SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00, and go next to MemRead if op=0000011, else MemWrite.
- REQ-023 MemRead SHALL drive AdrSrc=1, ResultSrc=00, and go next to MemWB.
- REQ-024 MemWB SHALL drive ResultSrc=01, RegWrite=1, and go next to Fetch.
- REQ-025 MemWrite SHALL drive AdrSrc=1, ResultSrc=00, MemWrite=1, and go next to Fetch.
- REQ-026 ExecuteR SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=10, and go next to ALUWB.
- REQ-027 ExecuteI SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=10, and go next to ALUWB.
- REQ-028 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1, and go next to ALUWB.
- REQ-029 ALUWB SHALL drive ResultSrc=00, RegWrite=1, and go next to Fetch.
- REQ-030 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, and go next to Fetch.
- REQ-031 Instruction latency, Fetch to next Fetch, SHALL be: lw 5 cycles; sw, R-type, I-type ALU and jal 4 cycles; beq 3 cycles; illegal op 2 cycles.
- REQ-032 In every state, at most one of RegWrite, MemWrite and IRWrite SHALL be 1.
- REQ-033 A change on op outside Decode, MemAdr or the cycle that samples it SHALL NOT affect outputs.

Reset
- REQ-034 While reset=1, the state SHALL be Fetch immediately, without waiting for a clock edge, with Fetch outputs driven (IRWrite=1, PCUpdate=1) and illegal_op=0.
- REQ-035 Reset asserted in any state, including mid-instruction (e.g. MemRead), SHALL abandon the instruction with no further RegWrite or MemWrite pulses.
- REQ-036 After reset deasserts, the first rising edge SHALL move the state to Decode.

Verification
- REQ-037 Scenario: reset, then op=0000011 -> states 0,1,2,3,4,0; exactly one RegWrite pulse, in state 4 with ResultSrc=01.
- REQ-038 Scenario: op=0100011 -> states 0,1,2,5,0; MemWrite=1 only in state 5 with AdrSrc=1; RegWrite never 1.
- REQ-039 Scenario: op=0110011, then op=0010011 -> states 0,1,6,7,0, then 0,1,8,7,0; ALUOp=10 in states 6 and 8; RegWrite=1 in state 7.
- REQ-040 Scenario: op=1101111, then op=1100011 -> jal: 0,1,9,7,0 with PCUpdate=1 in state 9; beq: 0,1,10,0 with Branch=1 and ALUOp=01 in state 10.
- REQ-041 Scenario: op=1111111 -> states 0,1,0; illegal_op=1 for exactly one cycle in state 1; no write enables asserted.
- REQ-042 Scenario: reset asserted asynchronously mid-cycle while in state 3 -> state=0 before the next clock edge; no RegWrite afterward until a new instruction reaches state 4.
